bf16_accumulator: RTL and testbench

- Downstream consumer of the bf16 multiplier stage. Accumulates a stream of bf16 products into a running bf16 sum and emits the sum when the element flagged last has been added.
- Each addition is a multi-cycle sequence (align, add, normalize, round) under an FSM.
- Valid/ready handshake on both sides. Sits between the multiplier array and the result writeback in dot-product datapaths.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_lzc8.sv | 17 +
 rtl/bf16_accumulator.sv | 223 ++++++++++++++++++++++
 tb/tb_bf16_accumulator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared bf16 definitions for the accumulator datapath: field widths,
// the max-finite constant, FSM states and a magnitude key helper.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 7;
  localparam int BF16_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS    = 127;
  // Aligned significand field: 8 significand bits followed by G, R, S.
  localparam int FIELD_W = MAN_W + 1 + 3;

  localparam logic [EXP_W+MAN_W-1:0] MAX_FINITE_MAG = 15'h7F7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_OUT
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } bf16_t;

  // Magnitude ordering key; a zero exponent flushes the operand to zero.
  function automatic logic [EXP_W+MAN_W-1:0] mag_key(input bf16_t v);
    return (v.exp == '0) ? '0 : {v.exp, v.mant};
  endfunction

endpackage

// File: rtl/fp_lzc8.sv
// Leading-zero counter for an 8-bit significand; returns 8 for an all-zero input.
module fp_lzc8 (
  input  logic [7:0] value,
  output logic [3:0] count
);

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    count = 4'd8;
    // Scanning upward lets the highest set bit have the final word.
    for (int i = 0; i < 8; i++) begin
      if (value[i]) count = 4'(7 - i);
    end
  end

endmodule

// File: rtl/bf16_accumulator.sv
// Streams bf16 products into a running bf16 sum, one multi-cycle add per
// element (align, add, normalize, round), and emits the sum on the last element.
module bf16_accumulator
  import fp_pkg::*;
#(
  parameter int SAT_ON_OVF = 1,
  parameter int BIAS       = 127
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        ovf_flag
);

  // Overflow always saturates; both modes raise the flag.
  localparam bit FLAG_ON_OVF = (SAT_ON_OVF == 0) || (SAT_ON_OVF == 1);
  localparam logic signed [9:0] EXP_LIMIT = 10'(2 * BIAS + 1);

  state_t state, state_next;

  logic ready_en;
  bf16_t acc;
  bf16_t op_q;
  logic  last_q;
  logic  ovf_q;

  logic               al_sign;
  logic [EXP_W-1:0]   al_exp;
  logic [FIELD_W-1:0] al_big;
  logic [FIELD_W-1:0] al_small;
  logic               al_sub;

  logic [FIELD_W:0]   sum_q;
  logic               ad_sign;
  logic [EXP_W-1:0]   ad_exp;

  logic [FIELD_W-1:0] nm_field;
  logic signed [9:0]  nm_exp;
  logic               nm_sign;
  logic               nm_zero;

  wire accept   = in_valid && in_ready;
  wire deliver  = out_valid && out_ready;

  assign in_ready  = ready_en && (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign out_data  = acc;
  assign ovf_flag  = ovf_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept) state_next = S_ALIGN;
      S_ALIGN: state_next = S_ADD;
      S_ADD:   state_next = S_NORM;
      S_NORM:  state_next = S_ROUND;
      S_ROUND: state_next = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (deliver) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- ALIGN
  bf16_t              big_c, small_c;
  logic [7:0]         sig_big_c, sig_small_c;
  logic [EXP_W-1:0]   diff_c;
  logic [FIELD_W-1:0] ext_c, shifted_c, aligned_c;
  logic               lost_c;

  always_comb begin
    if (mag_key(acc) >= mag_key(op_q)) begin
      big_c   = acc;
      small_c = op_q;
    end else begin
      big_c   = op_q;
      small_c = acc;
    end
    sig_big_c   = (big_c.exp   != '0) ? {1'b1, big_c.mant}   : 8'd0;
    sig_small_c = (small_c.exp != '0) ? {1'b1, small_c.mant} : 8'd0;
    diff_c      = big_c.exp - small_c.exp;
    ext_c       = {sig_small_c, 3'b000};
    shifted_c   = ext_c >> diff_c[3:0];
    lost_c      = |(ext_c & ~(11'h7FF << diff_c[3:0]));
    if (diff_c >= 8'(FIELD_W)) aligned_c = {10'd0, |sig_small_c};
    else                       aligned_c = {shifted_c[10:1], shifted_c[0] | lost_c};
  end

  // ---------------------------------------------------------------- ADD
  logic [FIELD_W:0] sum_c;

  always_comb begin
    if (al_sub) sum_c = {1'b0, al_big} - {1'b0, al_small};
    else        sum_c = {1'b0, al_big} + {1'b0, al_small};
  end

  // ---------------------------------------------------------------- NORM
  logic               hi_zero_c;
  logic [7:0]         lzc_in_c;
  logic [3:0]         lz_c;
  logic [4:0]         shift_c;
  logic [FIELD_W-1:0] norm_field_c;
  logic signed [9:0]  norm_exp_c;

  // A heavy cancellation can leave the leading one down in G; the second
  // pass over the G/R/S bits extends the count past the significand.
  assign hi_zero_c = (sum_q[10:3] == 8'd0);
  assign lzc_in_c  = hi_zero_c ? {sum_q[2:0], 5'd0} : sum_q[10:3];

  fp_lzc8 u_lzc (
    .value (lzc_in_c),
    .count (lz_c)
  );

  always_comb begin
    shift_c = {1'b0, lz_c} + (hi_zero_c ? 5'd8 : 5'd0);
    if (sum_q[FIELD_W]) begin
      norm_field_c = {sum_q[11:2], sum_q[1] | sum_q[0]};
      norm_exp_c   = $signed({2'b00, ad_exp}) + 10'sd1;
    end else begin
      norm_field_c = sum_q[10:0] << shift_c;
      norm_exp_c   = $signed({2'b00, ad_exp}) - $signed({5'b00000, shift_c});
    end
  end

  // ---------------------------------------------------------------- ROUND
  logic              rnd_c;
  logic [8:0]        sig_r_c;
  logic [MAN_W-1:0]  mant_r_c;
  logic signed [9:0] exp_r_c;
  logic              exp_ovf_c;
  bf16_t             result_c;

  always_comb begin
    rnd_c     = nm_field[2] & (nm_field[1] | nm_field[0] | nm_field[3]);
    sig_r_c   = {1'b0, nm_field[10:3]} + 9'(rnd_c);
    mant_r_c  = sig_r_c[8] ? sig_r_c[7:1] : sig_r_c[6:0];
    exp_r_c   = nm_exp + $signed({9'd0, sig_r_c[8]});
    exp_ovf_c = !nm_zero && (exp_r_c >= EXP_LIMIT);
    if (nm_zero)        result_c = '0;
    else if (exp_ovf_c) result_c = {nm_sign, MAX_FINITE_MAG};
    else                result_c = {nm_sign, exp_r_c[7:0], mant_r_c};
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      op_q     <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      al_sign  <= 1'b0;
      al_exp   <= '0;
      al_big   <= '0;
      al_small <= '0;
      al_sub   <= 1'b0;
      sum_q    <= '0;
      ad_sign  <= 1'b0;
      ad_exp   <= '0;
      nm_field <= '0;
      nm_exp   <= '0;
      nm_sign  <= 1'b0;
      nm_zero  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= bf16_t'(in_data);
            last_q <= in_last;
          end
        end
        S_ALIGN: begin
          al_sign  <= big_c.sign;
          al_exp   <= big_c.exp;
          al_big   <= {sig_big_c, 3'b000};
          al_small <= aligned_c;
          al_sub   <= big_c.sign ^ small_c.sign;
        end
        S_ADD: begin
          sum_q   <= sum_c;
          ad_sign <= al_sign;
          ad_exp  <= al_exp;
        end
        S_NORM: begin
          nm_field <= norm_field_c;
          nm_exp   <= norm_exp_c;
          nm_sign  <= ad_sign;
          nm_zero  <= (sum_q == '0) || (norm_exp_c <= 10'sd0);
        end
        S_ROUND: begin
          acc   <= result_c;
          ovf_q <= ovf_q | (exp_ovf_c & FLAG_ON_OVF);
        end
        S_OUT: begin
          if (deliver) begin
            acc   <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_accumulator.sv
// Directed self-checking bench for bf16_accumulator with hand-computed sums.
module tb_bf16_accumulator;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic [15:0] in_data   = 16'h0000;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        ovf_flag;

  int n_cmp = 0;
  int n_bad = 0;

  bf16_accumulator #(.SAT_ON_OVF(1), .BIAS(127)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_flag  (ovf_flag)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) check("send_timeout", 16'(in_ready), 16'h0001);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for the sum, checks it, holds out_ready low for 'hold' cycles,
  // then completes the handshake and checks the return to IDLE.
  task automatic recv(input string tag, input logic [15:0] exp_data,
                      input logic exp_ovf, input int exp_lat, input int hold);
    int lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_valid"}, 16'(out_valid), 16'h0001);
    if (exp_lat >= 0) check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_ovf"}, 16'(ovf_flag), 16'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({tag, "_hold_valid"}, 16'(out_valid), 16'h0001);
      check({tag, "_hold_data"}, out_data, exp_data);
      check({tag, "_hold_ovf"}, 16'(ovf_flag), 16'(exp_ovf));
      check({tag, "_hold_in_ready"}, 16'(in_ready), 16'h0000);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 16'(out_valid), 16'h0000);
    check({tag, "_done_in_ready"}, 16'(in_ready), 16'h0001);
  endtask

  initial begin
    // Reset state, including in_ready held low while in reset.
    #12;
    check("rst_in_ready", 16'(in_ready), 16'h0000);
    check("rst_out_valid", 16'(out_valid), 16'h0000);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_ovf", 16'(ovf_flag), 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_release_in_ready", 16'(in_ready), 16'h0001);

    // 1.0 + 2.0 = 3.0, four cycles after the last transfer.
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    recv("one_plus_two", 16'h4040, 1'b0, 4, 0);

    // Exact cancellation.
    send(16'h3F80, 1'b0);
    send(16'hBF80, 1'b1);
    recv("cancel", 16'h0000, 1'b0, 4, 0);

    // Ties: even lsb stays, odd lsb rounds up.
    send(16'h3F80, 1'b0);
    send(16'h3B80, 1'b1);
    recv("tie_even", 16'h3F80, 1'b0, 4, 0);
    send(16'h3F81, 1'b0);
    send(16'h3B80, 1'b1);
    recv("tie_odd", 16'h3F82, 1'b0, 4, 0);

    // Opposite signs with a one-bit left renormalisation: 1.0 - 2.0 = -1.0.
    send(16'h3F80, 1'b0);
    send(16'hC000, 1'b1);
    recv("sub_renorm", 16'hBF80, 1'b0, 4, 0);

    // Exponent difference of 11 leaves only sticky: no rounding.
    send(16'h3F80, 1'b0);
    send(16'h3A00, 1'b1);
    recv("far_sticky", 16'h3F80, 1'b0, 4, 0);

    // Overflow saturates and flags; the next group starts clean.
    send(16'h7F7F, 1'b0);
    send(16'h7F7F, 1'b1);
    recv("overflow", 16'h7F7F, 1'b1, 4, 0);
    send(16'h3F00, 1'b1);
    recv("after_ovf", 16'h3F00, 1'b0, 4, 0);

    // Backpressure: outputs stable for three cycles with out_ready low.
    send(16'h3F80, 1'b1);
    recv("backpressure", 16'h3F80, 1'b0, 4, 3);

    // Reset while the second add of a group is in ADD.
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0000);
    check("midrst_in_ready", 16'(in_ready), 16'h0000);
    check("midrst_out_data", out_data, 16'h0000);
    check("midrst_ovf", 16'(ovf_flag), 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_release_in_ready", 16'(in_ready), 16'h0001);
    send(16'h4040, 1'b1);
    recv("after_midrst", 16'h4040, 1'b0, 4, 0);

    // Zero operands traverse the FSM; -0 normalises to +0.
    send(16'h0000, 1'b0);
    send(16'h8000, 1'b0);
    send(16'h3F80, 1'b1);
    recv("zeros_then_one", 16'h3F80, 1'b0, 4, 0);
    send(16'h8000, 1'b1);
    recv("lone_neg_zero", 16'h0000, 1'b0, 4, 0);

    // A denormal input is flushed to zero.
    send(16'h0001, 1'b1);
    recv("denormal_flush", 16'h0000, 1'b0, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
